// File: rtl/mem_stage.sv
// Memory pipeline stage: latches the execute bus, resolves branches, captures and aligns load data.
// Optional misaligned-load check enabled by defining MS_LOAD_ALIGN_CHK_EN (adds output ms_ale).
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 121,
    parameter int MS_TO_WS_BUS_WD = 70,
    parameter int BR_BUS_WD       = 33
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [31:0]                ms_to_es_bus,
    output logic [BR_BUS_WD-1:0]       br_bus,
`ifdef MS_LOAD_ALIGN_CHK_EN
    output logic                       ms_ale,
`endif
    input  logic [31:0]                data_sram_rdata
);

    logic                       ms_valid_q;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_q;
    logic                       br_sent_q;
    logic                       first_cycle_q;
    logic                       rdata_held_q;
    logic [31:0]                rdata_buf_q;

    logic        ms_ready_go;
    logic        ms_entry;
    logic        ms_leave;
    logic [31:0] br_target;
    logic [8:0]  branch_op;
    logic        flag_c, flag_s, flag_o, flag_z;
    logic [4:0]  load_op;
    logic        mem_to_reg;
    logic        reg_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
    logic        br_cond;
    logic        br_taken;
    logic [31:0] eff_rdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic        ale;

    assign {br_target, branch_op, flag_c, flag_s, flag_o, flag_z,
            load_op, mem_to_reg, reg_we, dest, result, pc} = es_bus_q;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
    assign ms_entry       = es_to_ms_valid & ms_allowin;
    assign ms_leave       = ms_to_ws_valid & ws_allowin;

    assign br_cond = (branch_op[0] &  flag_z)
                   | (branch_op[1] & !flag_z)
                   | (branch_op[2] &  (flag_s ^ flag_o))
                   | (branch_op[3] & !(flag_s ^ flag_o))
                   | (branch_op[4] &  flag_c)
                   | (branch_op[5] & !flag_c)
                   | (|branch_op[8:6]);

    // One pulse per instruction; br_sent_q masks it for the rest of a stall.
    assign br_taken = ms_valid_q & br_cond & !br_sent_q;
    assign br_bus   = {br_taken, br_target};

    // SRAM data is only valid in the first cycle, so a stall replays the buffered copy.
    assign eff_rdata = rdata_held_q ? rdata_buf_q : data_sram_rdata;

    always_comb begin
        ld_byte = eff_rdata[7:0];
        case (result[1:0])
            2'd0:    ld_byte = eff_rdata[7:0];
            2'd1:    ld_byte = eff_rdata[15:8];
            2'd2:    ld_byte = eff_rdata[23:16];
            default: ld_byte = eff_rdata[31:24];
        endcase
    end

    assign ld_half = result[1] ? eff_rdata[31:16] : eff_rdata[15:0];

    always_comb begin
        load_data = 32'd0;
        if (load_op[0]) load_data = load_data | {{24{ld_byte[7]}}, ld_byte};
        if (load_op[1]) load_data = load_data | {{16{ld_half[15]}}, ld_half};
        if (load_op[2]) load_data = load_data | eff_rdata;
        if (load_op[3]) load_data = load_data | {24'd0, ld_byte};
        if (load_op[4]) load_data = load_data | {16'd0, ld_half};
    end

    assign final_result = mem_to_reg ? load_data : result;

`ifdef MS_LOAD_ALIGN_CHK_EN
    assign ale    = ms_valid_q & (((load_op[1] | load_op[4]) & result[0])
                                 | (load_op[2] & (result[1:0] != 2'd0)));
    assign ms_ale = ale;
`else
    assign ale = 1'b0;
`endif

    assign ms_to_ws_bus = {reg_we & !ale, dest, final_result, pc};
    assign ms_to_es_bus = final_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q    <= 1'b0;
            es_bus_q      <= '0;
            br_sent_q     <= 1'b0;
            first_cycle_q <= 1'b0;
            rdata_held_q  <= 1'b0;
            rdata_buf_q   <= 32'd0;
        end else begin
            if (ms_allowin) begin
                ms_valid_q <= es_to_ms_valid;
            end
            if (ms_entry) begin
                es_bus_q      <= es_to_ms_bus;
                br_sent_q     <= 1'b0;
                first_cycle_q <= 1'b1;
                rdata_held_q  <= 1'b0;
            end else begin
                first_cycle_q <= 1'b0;
                if (br_taken) begin
                    br_sent_q <= 1'b1;
                end
                if (ms_leave) begin
                    rdata_held_q <= 1'b0;
                end else if (first_cycle_q && !ws_allowin) begin
                    rdata_buf_q  <= data_sram_rdata;
                    rdata_held_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized traffic checked against an
// instruction-level reference model. Define MS_LOAD_ALIGN_CHK_EN to also check ms_ale.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [120:0] es_to_ms_bus;
    logic         ms_to_ws_valid;
    logic [69:0]  ms_to_ws_bus;
    logic [31:0]  ms_to_es_bus;
    logic [32:0]  br_bus;
    logic [31:0]  data_sram_rdata;
`ifdef MS_LOAD_ALIGN_CHK_EN
    logic         ms_ale;
`endif

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_to_es_bus    (ms_to_es_bus),
        .br_bus          (br_bus),
`ifdef MS_LOAD_ALIGN_CHK_EN
        .ms_ale          (ms_ale),
`endif
        .data_sram_rdata (data_sram_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: which instruction occupies the stage and what it has seen.
    logic         m_occ   = 1'b0;
    logic [120:0] m_bus   = '0;
    logic         m_sent  = 1'b0;
    logic         m_first = 1'b0;
    logic [31:0]  m_rdata = '0;

    // DUT samples from the most recent step
    logic         s_allowin, s_valid, s_br, s_ale;
    logic [31:0]  s_tgt, s_fwd;
    logic [69:0]  s_ws_bus;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [120:0] mk(input logic [31:0] tgt, input logic [8:0] bop,
                                        input logic [3:0] csoz, input logic [4:0] lop,
                                        input logic m2r, input logic we, input logic [4:0] dst,
                                        input logic [31:0] res, input logic [31:0] pc);
        return {tgt, bop, csoz, lop, m2r, we, dst, res, pc};
    endfunction

    task automatic step(input logic vin, input logic [120:0] bin, input logic ws,
                        input logic [31:0] rd, input logic rst);
        logic [31:0] tgt, res, pc, word, ld, fin;
        logic [8:0]  bop;
        logic [4:0]  lop, dst;
        logic        c, s, o, z, m2r, we, cond, e_br, e_allow, ale;
        logic [7:0]  b;
        logic [15:0] h;
        es_to_ms_valid  = vin;
        es_to_ms_bus    = bin;
        ws_allowin      = ws;
        data_sram_rdata = rd;
        reset           = rst;
        @(negedge clk);
        {tgt, bop, c, s, o, z, lop, m2r, we, dst, res, pc} = m_bus;
        cond = (bop[0] && z) || (bop[1] && !z) || (bop[2] && (s != o)) || (bop[3] && (s == o))
            || (bop[4] && c) || (bop[5] && !c) || (bop[8:6] != 0);
        e_br    = m_occ && cond && !m_sent;
        e_allow = !m_occ || ws;
        word = m_first ? rd : m_rdata;
        b    = 8'((word >> (8 * res[1:0])) & 32'hFF);
        h    = res[1] ? word[31:16] : word[15:0];
        ld   = 32'd0;
        if (lop[0]) ld = b[7] ? (32'hFFFFFF00 | 32'(b)) : 32'(b);
        if (lop[1]) ld = h[15] ? (32'hFFFF0000 | 32'(h)) : 32'(h);
        if (lop[2]) ld = word;
        if (lop[3]) ld = 32'(b);
        if (lop[4]) ld = 32'(h);
        fin = m2r ? ld : res;
`ifdef MS_LOAD_ALIGN_CHK_EN
        ale = m_occ && (((lop[1] || lop[4]) && (res[0] == 1'b1)) || (lop[2] && (res % 4 != 0)));
`else
        ale = 1'b0;
`endif
        s_allowin = ms_allowin;
        s_valid   = ms_to_ws_valid;
        s_br      = br_bus[32];
        s_tgt     = br_bus[31:0];
        s_ws_bus  = ms_to_ws_bus;
        s_fwd     = ms_to_es_bus;
`ifdef MS_LOAD_ALIGN_CHK_EN
        s_ale     = ms_ale;
        chk("ms_ale", 70'(s_ale), 70'(ale));
`else
        s_ale     = 1'b0;
`endif
        chk("ms_allowin", 70'(s_allowin), 70'(e_allow));
        chk("ms_to_ws_valid", 70'(s_valid), 70'(m_occ));
        chk("br_taken", 70'(s_br), 70'(e_br));
        if (m_occ) begin
            chk("ms_to_ws_bus", s_ws_bus, {we && !ale, dst, fin, pc});
            chk("ms_to_es_bus", 70'(s_fwd), 70'(fin));
        end
        if (e_br) chk("br_target", 70'(s_tgt), 70'(tgt));
        if (rst) begin
            m_occ = 1'b0; m_sent = 1'b0; m_first = 1'b0;
        end else begin
            if (m_first) m_rdata = rd;
            m_first = 1'b0;
            if (e_br) m_sent = 1'b1;
            if (e_allow) begin
                m_occ = vin;
                if (vin) begin
                    m_bus = bin; m_sent = 1'b0; m_first = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [120:0] rand_bus();
        int          k;
        logic [8:0]  bop;
        logic [4:0]  lop;
        logic        m2r;
        k   = $urandom_range(0, 12);
        bop = (k < 9) ? 9'(1 << k) : 9'd0;
        m2r = 1'($urandom_range(0, 1));
        k   = $urandom_range(0, m2r ? 4 : 6);
        lop = (k < 5) ? 5'(1 << k) : 5'd0;
        return mk($urandom, bop, 4'($urandom), lop, m2r, 1'($urandom), 5'($urandom),
                  $urandom, $urandom);
    endfunction

    int pulses;
    logic [120:0] nop = '0;

    initial begin
        reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0; data_sram_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step(1'b0, nop, 1'b1, 32'd0, 1'b1);
        step(1'b0, nop, 1'b1, 32'd0, 1'b0);
        chk("reset valid", 70'(s_valid), 70'd0);
        chk("reset br", 70'(s_br), 70'd0);
        chk("reset allowin", 70'(s_allowin), 70'd1);

        // beq taken, single pulse
        step(1'b1, mk(32'h1C000040, 9'h001, 4'b0001, 5'd0, 1'b0, 1'b1, 5'd3, 32'h5, 32'h1C000000),
             1'b1, 32'd0, 1'b0);
        step(1'b0, nop, 1'b1, 32'd0, 1'b0);
        chk("beq br", 70'(s_br), 70'd1);
        chk("beq target", 70'(s_tgt), 70'h1C000040);
        step(1'b0, nop, 1'b1, 32'd0, 1'b0);
        chk("beq pulse end", 70'(s_br), 70'd0);

        // blt with S==O not taken, result passes
        step(1'b1, mk(32'h1C000080, 9'h004, 4'b0110, 5'd0, 1'b0, 1'b1, 5'd7, 32'h12345678, 32'h1C000010),
             1'b1, 32'd0, 1'b0);
        step(1'b0, nop, 1'b1, 32'd0, 1'b0);
        chk("blt br", 70'(s_br), 70'd0);
        chk("blt result", 70'(s_ws_bus[63:32]), 70'h12345678);

        // ld.b / ld.bu at byte 3
        step(1'b1, mk(32'd0, 9'd0, 4'd0, 5'b00001, 1'b1, 1'b1, 5'd4, 32'h00001003, 32'h1C000020),
             1'b1, 32'd0, 1'b0);
        step(1'b1, mk(32'd0, 9'd0, 4'd0, 5'b01000, 1'b1, 1'b1, 5'd5, 32'h00001003, 32'h1C000024),
             1'b1, 32'h80FF1234, 1'b0);
        chk("ld.b", 70'(s_fwd), 70'hFFFFFF80);
        step(1'b0, nop, 1'b1, 32'h80FF1234, 1'b0);
        chk("ld.bu", 70'(s_fwd), 70'h00000080);

        // ld.h at addr 2 held across a stall while rdata changes
        step(1'b1, mk(32'd0, 9'd0, 4'd0, 5'b00010, 1'b1, 1'b1, 5'd6, 32'h00002002, 32'h1C000028),
             1'b1, 32'd0, 1'b0);
        step(1'b0, nop, 1'b0, 32'h1234ABCD, 1'b0);
        step(1'b0, nop, 1'b0, 32'd0, 1'b0);
        step(1'b0, nop, 1'b0, 32'd0, 1'b0);
        step(1'b0, nop, 1'b1, 32'd0, 1'b0);
        chk("ld.h stalled", 70'(s_fwd), 70'h00001234);

        // bne taken during a 4-cycle stall: one pulse, then next branch fires
        pulses = 0;
        step(1'b1, mk(32'h1C000100, 9'h002, 4'b0000, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h1C000030),
             1'b1, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, nop, 1'b0, 32'd0, 1'b0);
            pulses += int'(s_br);
        end
        step(1'b1, mk(32'h1C000200, 9'h002, 4'b0000, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h1C000034),
             1'b1, 32'd0, 1'b0);
        pulses += int'(s_br);
        chk("bne pulses", 70'(pulses), 70'd1);
        step(1'b0, nop, 1'b1, 32'd0, 1'b0);
        chk("bne next br", 70'(s_br), 70'd1);
        chk("bne next target", 70'(s_tgt), 70'h1C000200);

        // Reset during a stalled load
        step(1'b1, mk(32'd0, 9'd0, 4'd0, 5'b00100, 1'b1, 1'b1, 5'd8, 32'h00003000, 32'h1C000040),
             1'b1, 32'd0, 1'b0);
        step(1'b0, nop, 1'b0, 32'hCAFEF00D, 1'b0);
        step(1'b0, nop, 1'b0, 32'd0, 1'b1);
        step(1'b0, nop, 1'b0, 32'd0, 1'b0);
        chk("rst stall valid", 70'(s_valid), 70'd0);
        chk("rst stall br", 70'(s_br), 70'd0);

`ifdef MS_LOAD_ALIGN_CHK_EN
        step(1'b1, mk(32'd0, 9'd0, 4'd0, 5'b00100, 1'b1, 1'b1, 5'd9, 32'h00004002, 32'h1C000044),
             1'b1, 32'd0, 1'b0);
        step(1'b0, nop, 1'b1, 32'h11223344, 1'b0);
        chk("ale flag", 70'(s_ale), 70'd1);
        chk("ale reg_we", 70'(s_ws_bus[69]), 70'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), rand_bus(), ($urandom_range(0, 9) < 6),
                 $urandom, ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
